// File: rtl/sram_controller.sv
// Cache-side word write / block read engine over a 16-bit async SRAM; write ready at 2*AC+1, read at 4*AC+1.
// No backpressure: request is a level held until the one-cycle ready pulse, inputs latched on accept.
module sram_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        write_en,
  input  logic        read_en,
  output logic [63:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  // wrd is the word offset from BASE_ADDR; its upper bits form the block index
  typedef struct packed {
    logic [16:0] wrd;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [1:0]  beat;
  logic [3:0]  cyc;
  logic [15:0] hw0, hw1, hw2;
  logic        last_cyc;
  logic        start;

  assign last_cyc = (cyc == 4'(ACCESS_CYCLES - 1));
  assign start    = (state == IDLE) && (write_en || read_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    case (state)
      IDLE: begin
        if (write_en)     state_nxt = WRITE;
        else if (read_en) state_nxt = READ;
      end
      WRITE: begin
        sram_addr   = {req.wrd, beat[0]};
        sram_dq_out = beat[0] ? req.wdata[31:16] : req.wdata[15:0];
        sram_dq_oe  = 1'b1;
        // release the strobe on the final cycle so every beat ends with a rising edge
        sram_we_n   = last_cyc;
        if (last_cyc && beat[0]) state_nxt = DONE;
      end
      READ: begin
        sram_addr = {req.wrd[16:1], beat};
        sram_oe_n = 1'b0;
        if (last_cyc && (beat == 2'd3)) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req   <= '0;
      beat  <= 2'd0;
      cyc   <= 4'd0;
      hw0   <= 16'd0;
      hw1   <= 16'd0;
      hw2   <= 16'd0;
      rdata <= 64'd0;
    end else begin
      if (start) begin
        // BASE_ADDR is 8-byte aligned, so subtracting at word granularity cannot borrow
        req   <= '{wrd: address[18:2] - 17'(BASE_ADDR >> 2), wdata: wdata};
        beat  <= 2'd0;
        cyc   <= 4'd0;
      end else if (state == WRITE || state == READ) begin
        if (last_cyc) begin
          cyc  <= 4'd0;
          beat <= beat + 2'd1;
        end else begin
          cyc  <= cyc + 4'd1;
        end
      end
      if (state == READ && last_cyc) begin
        case (beat)
          2'd0: hw0 <= sram_dq_in;
          2'd1: hw1 <= sram_dq_in;
          2'd2: hw2 <= sram_dq_in;
          // the final halfword goes straight into rdata so it is valid on entry to DONE
          default: rdata <= req.wrd[0] ? {sram_dq_in, hw2, hw1, hw0}
                                       : {hw1, hw0, sram_dq_in, hw2};
        endcase
      end
    end
  end

endmodule
